// File: rtl/floor_id_logic.sv
// Occupancy/ID engine for the two-floor parking controller: ID classification, floor-full flags, per-pool counters.
// Optional feature macro FLOOR_ID_ADMIN_EN adds the administrator ID compare and the MODE 2 counter restore.
module floor_id_logic #(
   parameter logic [2:0]  SPEC_CAP_0 = 3'd2,
   parameter logic [2:0]  NORM_CAP_0 = 3'd4,
   parameter logic [2:0]  CAP_1      = 3'd6
`ifdef FLOOR_ID_ADMIN_EN
   ,
   parameter logic [27:0] ADMIN_ID   = 28'h1234567
`endif
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic [27:0] ID,
   input  logic        chosen_flr,
   input  logic [1:0]  action_taken,
   input  logic [1:0]  MODE,
   output logic        id_valid,
   output logic        id_special,
   output logic        special_flr_chosen,
   output logic        chosen_flr_full,
   output logic        alternative_flr_full,
   output logic        adminId_valid,
   output logic [2:0]  remain_flr_spec_0,
   output logic [2:0]  remain_flr_norm_0,
   output logic [2:0]  remain_flr_1
);

   logic [6:0] digit_ok;
   logic       admin_match;
   logic       flr0_full;
   logic       flr1_full;
   logic       act_edge;
   logic       tgt_flr;

   logic [1:0] prev_act_reg;
   logic [2:0] spec0_reg, spec0_next;
   logic [2:0] norm0_reg, norm0_next;
   logic [2:0] flr1_reg,  flr1_next;

   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_digit
         assign digit_ok[gi] = (ID[gi*4 +: 4] <= 4'd9);
      end
   endgenerate

`ifdef FLOOR_ID_ADMIN_EN
   assign admin_match = (ID == ADMIN_ID);
`else
   assign admin_match = 1'b0;
`endif

   assign adminId_valid      = admin_match;
   assign id_valid           = (&digit_ok) && (ID != 28'd0) && !admin_match;
   assign id_special         = id_valid && (ID[27:24] == 4'd9);
   assign special_flr_chosen = (chosen_flr == 1'b0);

   // A special ID may park in either floor-0 pool, so floor 0 is full for it only when both are empty.
   assign flr0_full = id_special ? ((spec0_reg == 3'd0) && (norm0_reg == 3'd0))
                                 : (norm0_reg == 3'd0);
   assign flr1_full = (flr1_reg == 3'd0);

   assign chosen_flr_full      = chosen_flr ? flr1_full : flr0_full;
   assign alternative_flr_full = chosen_flr ? flr0_full : flr1_full;

   // Only the rising edge of a real grant counts; action 3 never touches the counters.
   assign act_edge = (prev_act_reg == 2'd0) && (action_taken == 2'd1 || action_taken == 2'd2);
   assign tgt_flr  = (action_taken == 2'd2) ? chosen_flr : ~chosen_flr;

   always_comb begin
      spec0_next = spec0_reg;
      norm0_next = norm0_reg;
      flr1_next  = flr1_reg;
      if (act_edge) begin
         case (MODE)
            2'd0: begin
               if (tgt_flr) begin
                  if (flr1_reg != 3'd0) flr1_next = flr1_reg - 3'd1;
               end else if (id_special && spec0_reg != 3'd0) begin
                  spec0_next = spec0_reg - 3'd1;
               end else if (norm0_reg != 3'd0) begin
                  norm0_next = norm0_reg - 3'd1;
               end
            end
            2'd1: begin
               if (tgt_flr) begin
                  if (flr1_reg < CAP_1) flr1_next = flr1_reg + 3'd1;
               end else if (id_special && spec0_reg < SPEC_CAP_0) begin
                  spec0_next = spec0_reg + 3'd1;
               end else if (norm0_reg < NORM_CAP_0) begin
                  norm0_next = norm0_reg + 3'd1;
               end
            end
            2'd2: begin
               if (admin_match) begin
                  spec0_next = SPEC_CAP_0;
                  norm0_next = NORM_CAP_0;
                  flr1_next  = CAP_1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         prev_act_reg <= 2'd0;
         spec0_reg    <= SPEC_CAP_0;
         norm0_reg    <= NORM_CAP_0;
         flr1_reg     <= CAP_1;
      end else begin
         prev_act_reg <= action_taken;
         spec0_reg    <= spec0_next;
         norm0_reg    <= norm0_next;
         flr1_reg     <= flr1_next;
      end
   end

   assign remain_flr_spec_0 = spec0_reg;
   assign remain_flr_norm_0 = norm0_reg;
   assign remain_flr_1      = flr1_reg;

endmodule

// File: tb/tb_floor_id_logic.sv
// Scoreboard bench for floor_id_logic: expectations are queued with each stimulus and checked after the clock.
module tb_floor_id_logic;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic [27:0] ID;
   logic        chosen_flr;
   logic [1:0]  action_taken;
   logic [1:0]  MODE;
   logic        id_valid, id_special, special_flr_chosen;
   logic        chosen_flr_full, alternative_flr_full, adminId_valid;
   logic [2:0]  remain_flr_spec_0, remain_flr_norm_0, remain_flr_1;

   floor_id_logic dut (
      .CLK                  (CLK),
      .reset_n              (reset_n),
      .ID                   (ID),
      .chosen_flr           (chosen_flr),
      .action_taken         (action_taken),
      .MODE                 (MODE),
      .id_valid             (id_valid),
      .id_special           (id_special),
      .special_flr_chosen   (special_flr_chosen),
      .chosen_flr_full      (chosen_flr_full),
      .alternative_flr_full (alternative_flr_full),
      .adminId_valid        (adminId_valid),
      .remain_flr_spec_0    (remain_flr_spec_0),
      .remain_flr_norm_0    (remain_flr_norm_0),
      .remain_flr_1         (remain_flr_1)
   );

   always #5 CLK = ~CLK;

   localparam int S_VALID = 0, S_SPECIAL = 1, S_SPCHOSEN = 2, S_CFULL = 3, S_AFULL = 4,
                  S_ADMIN = 5, S_SPEC0 = 6, S_NORM0 = 7, S_FLR1 = 8;

   typedef struct {
      string      tag;
      int         sig;
      logic [7:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_txn = 0;

   function automatic logic [7:0] observe(int sig);
      case (sig)
         S_VALID:    return {7'd0, id_valid};
         S_SPECIAL:  return {7'd0, id_special};
         S_SPCHOSEN: return {7'd0, special_flr_chosen};
         S_CFULL:    return {7'd0, chosen_flr_full};
         S_AFULL:    return {7'd0, alternative_flr_full};
         S_ADMIN:    return {7'd0, adminId_valid};
         S_SPEC0:    return {5'd0, remain_flr_spec_0};
         S_NORM0:    return {5'd0, remain_flr_norm_0};
         S_FLR1:     return {5'd0, remain_flr_1};
         default:    return 8'hFF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input int sig, input logic [7:0] exp);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic expect_cnt(input string tag, input int s0, input int n0, input int f1);
      expect_val({tag, "_spec0"}, S_SPEC0, 8'(s0));
      expect_val({tag, "_norm0"}, S_NORM0, 8'(n0));
      expect_val({tag, "_flr1"},  S_FLR1,  8'(f1));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.tag, observe(e.sig), e.exp);
         n++;
      end
      n_txn++;
      $display("txn %0d %s: %0d checks, counts %0d/%0d/%0d", n_txn, name, n,
               remain_flr_spec_0, remain_flr_norm_0, remain_flr_1);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One grant: action asserted for a single cycle, then released for one cycle.
   task automatic grant(input logic [1:0] act);
      action_taken = act;
      tick();
      action_taken = 2'd0;
      tick();
   endtask

   initial begin
      reset_n      = 1'b0;
      ID           = 28'd0;
      chosen_flr   = 1'b0;
      action_taken = 2'd0;
      MODE         = 2'd3;
      tick();
      reset_n = 1'b1;
      expect_cnt("reset", 2, 4, 6);
      expect_val("reset_idv", S_VALID, 8'd0);
      drain("reset");

      // Held grant updates exactly once.
      ID = 28'h0000042; chosen_flr = 1'b1; MODE = 2'd0; #1;
      expect_val("enter_cfull", S_CFULL, 8'd0);
      expect_val("enter_idv", S_VALID, 8'd1);
      drain("enter_flags");
      action_taken = 2'd2;
      repeat (4) tick();
      action_taken = 2'd0;
      tick();
      expect_cnt("enter_held", 2, 4, 5);
      drain("enter_held");

      // Special ID on floor 0: special pool first, then normal.
      ID = 28'h9000001; chosen_flr = 1'b0; #1;
      expect_val("spec_idsp", S_SPECIAL, 8'd1);
      expect_val("spec_flrch", S_SPCHOSEN, 8'd1);
      drain("special_flags");
      grant(2'd2); expect_cnt("spec_g1", 1, 4, 5); drain("special_g1");
      grant(2'd2); expect_cnt("spec_g2", 0, 4, 5); drain("special_g2");
      grant(2'd2); expect_cnt("spec_g3", 0, 3, 5); drain("special_g3");

      // Drain floor 1, check full flags and no underflow, then take the alternative floor.
      ID = 28'h0000042; chosen_flr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         grant(2'd2);
         expect_val("drain_flr1", S_FLR1, 8'(4 - i));
         drain("drain_flr1");
      end
      expect_val("full_cfull", S_CFULL, 8'd1);
      expect_val("full_afull", S_AFULL, 8'd0);
      drain("full_flags");
      grant(2'd2); expect_cnt("underflow", 0, 3, 0); drain("underflow");
      grant(2'd1); expect_cnt("alt_grant", 0, 2, 0); drain("alt_grant");
      grant(2'd3); expect_cnt("act3_noop", 0, 2, 0); drain("act3_noop");

      // Malformed ID, then exits with saturation on both floors.
      ID = 28'h00000A3; #1;
      expect_val("bad_idv", S_VALID, 8'd0);
      expect_val("bad_idsp", S_SPECIAL, 8'd0);
      drain("bad_id");
      ID = 28'h0000042; chosen_flr = 1'b1; MODE = 2'd1;
      for (int i = 0; i < 7; i++) begin
         grant(2'd2);
         expect_val("exit_flr1", S_FLR1, 8'((i + 1 > 6) ? 6 : i + 1));
         drain("exit_flr1");
      end
      ID = 28'h9000001; chosen_flr = 1'b0;
      grant(2'd2); expect_cnt("exit_sp1", 1, 2, 6); drain("exit_special1");
      grant(2'd2); expect_cnt("exit_sp2", 2, 2, 6); drain("exit_special2");
      grant(2'd2); expect_cnt("exit_sp3", 2, 3, 6); drain("exit_special3");
      grant(2'd2); expect_cnt("exit_sp4", 2, 4, 6); drain("exit_special4");
      grant(2'd2); expect_cnt("exit_sp5", 2, 4, 6); drain("exit_special5");

      // Reset on the same edge as an action edge discards the action.
      ID = 28'h0000042; chosen_flr = 1'b1; MODE = 2'd0;
      grant(2'd2); expect_cnt("pre_rst", 2, 4, 5); drain("pre_reset");
      reset_n = 1'b0; action_taken = 2'd2;
      tick();
      reset_n = 1'b1; action_taken = 2'd0;
      expect_cnt("rst_wins", 2, 4, 6);
      drain("reset_wins");
      tick();
      expect_cnt("post_rst", 2, 4, 6);
      drain("post_reset");

      // Administrator restore (or its absence).
      grant(2'd2); expect_cnt("pre_admin", 2, 4, 5); drain("pre_admin");
      ID = 28'h1234567; MODE = 2'd2; #1;
`ifdef FLOOR_ID_ADMIN_EN
      expect_val("admin_flag", S_ADMIN, 8'd1);
      expect_val("admin_idv", S_VALID, 8'd0);
      drain("admin_flags");
      grant(2'd2); expect_cnt("admin_restore", 2, 4, 6); drain("admin_restore");
`else
      expect_val("admin_flag", S_ADMIN, 8'd0);
      expect_val("admin_idv", S_VALID, 8'd1);
      drain("admin_flags");
      grant(2'd2); expect_cnt("admin_noop", 2, 4, 5); drain("admin_noop");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
